// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-granular round-robin arbiter sharing one FIFO write port among NREQ sources
// Ports:
//   clk, rst                       FIFO write clock, async active-high reset
//   en_mask                        per-source eligibility for new grants
//   src_valid/src_data/src_last    per-source beat stream, data at [i*DW +: DW]
//   src_ready                      per-source accept (valid & ready = transfer)
//   fifo_din, fifo_we, fifo_full   FIFO write port
//   busy, grant_id                 grant held / current or last granted source
//   timeout_pulse, pkt_count       stall revocation pulse / completed packet count
module fifo_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW = 8,
  parameter int IDW = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   en_mask,
  input  logic [NREQ-1:0]   src_valid,
  input  logic [NREQ*DW-1:0] src_data,
  input  logic [NREQ-1:0]   src_last,
  output logic [NREQ-1:0]   src_ready,
  output logic [DW-1:0]     fifo_din,
  output logic              fifo_we,
  input  logic              fifo_full,
  output logic              busy,
  output logic [IDW-1:0]    grant_id,
  output logic              timeout_pulse,
  output logic [15:0]       pkt_count
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [1:0] rst_sync;
  logic arst;
  logic [IDW-1:0] rr_ptr, pick;
  logic [15:0] to_cnt;
  logic [NREQ-1:0] elig;
  logic g_valid, xfer, stall_idle, to_hit;
  // assertion is immediate, release is aligned to clk
  always_ff @(posedge clk or posedge rst)
    if (rst) rst_sync <= 2'b11;
    else rst_sync <= {rst_sync[0], 1'b0};
  assign arst = rst_sync[1];
  assign elig = src_valid & en_mask;
  // scan downward so the index closest above rr_ptr wins
  always_comb begin
    pick = '0;
    for (int k = NREQ; k >= 1; k--)
      if (elig[(int'(rr_ptr) + k) % NREQ]) pick = IDW'((int'(rr_ptr) + k) % NREQ);
  end
  assign busy = state == BUSY;
  assign g_valid = src_valid[grant_id];
  assign xfer = busy && g_valid && !fifo_full;
  assign stall_idle = busy && !g_valid && !fifo_full;
  assign to_hit = stall_idle && to_cnt == 16'(TIMEOUT - 1);
  assign src_ready = (busy && !fifo_full) ? (NREQ'(1) << grant_id) : '0;
  assign fifo_we = xfer;
  assign fifo_din = src_data[grant_id*DW +: DW];
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      state <= IDLE;
      grant_id <= '0;
      rr_ptr <= IDW'(NREQ - 1);
      to_cnt <= '0;
      pkt_count <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      if (state == IDLE) begin
        to_cnt <= '0;
        if (|elig) begin
          grant_id <= pick;
          state <= BUSY;
        end
      end else begin
        to_cnt <= xfer ? '0 : stall_idle ? to_cnt + 16'd1 : to_cnt;
        if (xfer && src_last[grant_id]) begin
          state <= IDLE;
          rr_ptr <= grant_id;
          pkt_count <= pkt_count + 16'd1;
        end else if (to_hit) begin
          state <= IDLE;
          rr_ptr <= grant_id;
          timeout_pulse <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench for fifo_wr_arbiter with directed packet streams
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 0, rst = 0;
  logic [N-1:0] en_mask, src_valid, src_last, src_ready;
  logic [N*W-1:0] src_data;
  logic [W-1:0] fifo_din;
  logic fifo_we, fifo_full, busy, timeout_pulse;
  logic [1:0] grant_id;
  logic [15:0] pkt_count;
  int total = 0, bad = 0, cyc = 0, nwr = 0, to_seen = 0, c0 = 0;
  int left[N], npk[N], pk[N], bt[N], len[N];
  bit stall[N];
  logic [W-1:0] expq[$];
  int wcyc[$];
  logic [N-1:0] xcap;

  fifo_wr_arbiter #(.NREQ(N), .DW(W), .IDW(2), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .en_mask(en_mask), .src_valid(src_valid), .src_data(src_data),
    .src_last(src_last), .src_ready(src_ready), .fifo_din(fifo_din), .fifo_we(fifo_we),
    .fifo_full(fifo_full), .busy(busy), .grant_id(grant_id), .timeout_pulse(timeout_pulse),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] beat(input int i, input int p, input int b);
    return 8'(i * 64 + (p % 8) * 8 + (b % 8));
  endfunction

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", n, a, e);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      src_valid[i] = left[i] > 0 && !stall[i];
      src_last[i] = left[i] == 1;
      src_data[i*W +: W] = beat(i, pk[i], bt[i]);
    end
  endtask

  task automatic load(input int i, input int n, input int l);
    len[i] = l; npk[i] = n - 1; pk[i] = 0; bt[i] = 0; left[i] = l; stall[i] = 0;
  endtask

  task automatic exp_pkt(input int i, input int p, input int l);
    for (int b = 0; b < l; b++) expq.push_back(beat(i, p, b));
  endtask

  task automatic tick();
    @(negedge clk);
    xcap = src_valid & src_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (xcap[i]) begin
        bt[i]++; left[i]--;
        if (left[i] == 0 && npk[i] > 0) begin
          npk[i]--; pk[i]++; bt[i] = 0; left[i] = len[i];
        end
      end
    drive();
  endtask

  task automatic wait_wr(input int n, input int budget);
    int k = 0;
    while (nwr < n && k < budget) begin
      tick();
      k++;
    end
    chk("write_count_reached", nwr, n);
  endtask

  task automatic do_reset();
    rst = 1;
    for (int i = 0; i < N; i++) begin
      left[i] = 0; npk[i] = 0; pk[i] = 0; bt[i] = 0; stall[i] = 0; len[i] = 0;
    end
    fifo_full = 0;
    en_mask = '1;
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (3) @(posedge clk);
    #1;
    expq.delete();
    wcyc.delete();
    nwr = 0;
    to_seen = 0;
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (timeout_pulse) to_seen++;
      if (fifo_full) chk("no_write_when_full", int'({fifo_we, src_ready}), 0);
      if (fifo_we) begin
        nwr++;
        wcyc.push_back(cyc);
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_write din=%0d", fifo_din);
        end else chk("fifo_din", fifo_din, expq.pop_front());
      end
    end

  initial begin
    fifo_full = 0;
    en_mask = '1;
    for (int i = 0; i < N; i++) begin
      left[i] = 0; npk[i] = 0; pk[i] = 0; bt[i] = 0; stall[i] = 0; len[i] = 0;
    end
    drive();
    #2 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_fifo_we", fifo_we, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_timeout_pulse", timeout_pulse, 0);

    // two contending 3-beat packets
    do_reset();
    load(0, 1, 3); load(2, 1, 3); drive();
    c0 = cyc;
    exp_pkt(0, 0, 3); exp_pkt(2, 0, 3);
    wait_wr(6, 40);
    repeat (3) tick();
    chk("t1_pkt_count", pkt_count, 2);
    chk("t1_grant_id", grant_id, 2);
    chk("t1_busy", busy, 0);
    chk("t1_queue_empty", expq.size(), 0);
    if (wcyc.size() == 6) begin
      chk("t1_first_latency", wcyc[0] - c0, 1);
      chk("t1_gap0", wcyc[1] - wcyc[0], 1);
      chk("t1_gap1", wcyc[2] - wcyc[1], 1);
      chk("t1_idle_gap", wcyc[3] - wcyc[2], 2);
      chk("t1_gap3", wcyc[4] - wcyc[3], 1);
      chk("t1_gap4", wcyc[5] - wcyc[4], 1);
    end else chk("t1_write_log", wcyc.size(), 6);

    // all sources, single-beat packets
    do_reset();
    for (int i = 0; i < N; i++) load(i, 2, 1);
    drive();
    for (int p = 0; p < 2; p++) for (int i = 0; i < N; i++) exp_pkt(i, p, 1);
    wait_wr(8, 60);
    repeat (2) tick();
    chk("t2_pkt_count", pkt_count, 8);
    chk("t2_queue_empty", expq.size(), 0);
    if (wcyc.size() == 8) begin
      for (int k = 1; k < 8; k++) chk("t2_write_spacing", wcyc[k] - wcyc[k-1], 2);
    end else chk("t2_write_log", wcyc.size(), 8);

    // FIFO full mid-packet
    do_reset();
    load(1, 1, 4); drive();
    exp_pkt(1, 0, 4);
    wait_wr(2, 10);
    fifo_full = 1;
    repeat (5) begin
      tick();
      chk("t3_busy_while_full", busy, 1);
    end
    chk("t3_no_write_while_full", nwr, 2);
    fifo_full = 0;
    wait_wr(4, 10);
    repeat (2) tick();
    chk("t3_pkt_count", pkt_count, 1);
    chk("t3_no_timeout", to_seen, 0);
    chk("t3_queue_empty", expq.size(), 0);

    // stall timeout
    do_reset();
    load(0, 1, 3); drive();
    exp_pkt(0, 0, 1); exp_pkt(3, 0, 1);
    wait_wr(1, 10);
    stall[0] = 1;
    load(3, 1, 1);
    drive();
    repeat (3) begin
      tick();
      chk("t4_busy_during_stall", busy, 1);
      chk("t4_no_pulse_yet", timeout_pulse, 0);
    end
    tick();
    chk("t4_busy_dropped", busy, 0);
    chk("t4_timeout_pulse", timeout_pulse, 1);
    chk("t4_pkt_unchanged", pkt_count, 0);
    tick();
    chk("t4_regrant_busy", busy, 1);
    chk("t4_regrant_id", grant_id, 3);
    chk("t4_pulse_one_cycle", timeout_pulse, 0);
    wait_wr(2, 10);
    repeat (2) tick();
    chk("t4_pkt_count", pkt_count, 1);
    chk("t4_pulse_count", to_seen, 1);
    chk("t4_queue_empty", expq.size(), 0);

    // enable mask
    do_reset();
    en_mask = 4'b0100;
    for (int i = 0; i < N; i++) load(i, 1, 3);
    drive();
    exp_pkt(2, 0, 3);
    wait_wr(1, 10);
    en_mask = 4'b0000;
    wait_wr(3, 10);
    repeat (6) tick();
    chk("t5_busy", busy, 0);
    chk("t5_grant_id", grant_id, 2);
    chk("t5_pkt_count", pkt_count, 1);
    chk("t5_writes", nwr, 3);
    chk("t5_queue_empty", expq.size(), 0);

    // reset during beat 2
    do_reset();
    load(2, 1, 4); drive();
    exp_pkt(2, 0, 2);
    wait_wr(2, 10);
    chk("t6_pre_rst_we", fifo_we, 1);
    #2 rst = 1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_we", fifo_we, 0);
    chk("t6_rst_ready", src_ready, 0);
    chk("t6_rst_grant_id", grant_id, 0);
    chk("t6_rst_pkt_count", pkt_count, 0);
    chk("t6_queue_empty", expq.size(), 0);
    do_reset();
    load(0, 1, 1); load(3, 1, 1); drive();
    exp_pkt(0, 0, 1); exp_pkt(3, 0, 1);
    wait_wr(2, 20);
    repeat (2) tick();
    chk("t6_pkt_count", pkt_count, 2);
    chk("t6_final_queue_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the write port of one dual-clock FIFO wrapper among NREQ streaming sources.
- Sits entirely in the FIFO write-clock domain, in front of the FIFO.
- Holds a grant for a whole packet (until the beat flagged last), honours FIFO full, and releases the grant of a source that stalls mid-packet.

Parameters:
- NREQ, 4, number of requesting sources (2..8).
- DW, 8, data width; equals the FIFO dw.
- IDW, 2, grant index width; must satisfy 2**IDW >= NREQ.
- TIMEOUT, 255, idle cycles allowed mid-packet before the grant is revoked (1..65535).

Ports:
- clk  in  1  FIFO write clock.
- rst  in  1  asynchronous, active-high reset.
- en_mask  in  NREQ  per-source enable; a cleared bit makes that source ineligible for new grants.
- src_valid  in  NREQ  source i presents a beat.
- src_data  in  NREQ*DW  source i data at bits [i*DW +: DW].
- src_last  in  NREQ  beat is the final beat of a packet.
- src_ready  out  NREQ  beat accepted this cycle (valid & ready = transfer).
- fifo_din  out  DW  to FIFO din.
- fifo_we  out  1  to FIFO we.
- fifo_full  in  1  from FIFO full.
- busy  out  1  a grant is held.
- grant_id  out  IDW  index of the current or last granted source.
- timeout_pulse  out  1  one-cycle pulse when a grant is revoked by timeout.
- pkt_count  out  16  completed packets (last beat written), wraps at 65535->0.

Behaviour:
- Reset (async assert, synchronous release by clk):
  - state=IDLE, busy=0, grant_id=0, rr pointer=NREQ-1.
  - timeout counter=0, pkt_count=0, timeout_pulse=0.
  - src_ready=0, fifo_we=0.
- States IDLE, BUSY.
- IDLE:
  - Eligible set = src_valid & en_mask.
  - If the set is non-empty, pick the first eligible index searching upward from rr pointer+1 (mod NREQ).
  - Register that index as grant_id, set busy=1, go to BUSY next cycle.
  - No transfer occurs in IDLE: src_ready=0, fifo_we=0.
- BUSY datapath (combinational from registered grant):
  - src_ready[grant_id] = ~fifo_full; all other ready bits are 0.
  - fifo_we = src_valid[grant_id] & ~fifo_full.
  - fifo_din = src_data slice of grant_id.
  - No write is ever issued while fifo_full=1.
- BUSY transitions:
  - Transfer with src_last[grant_id]=1: go to IDLE, rr pointer<=grant_id, pkt_count+1.
  - Timeout: src_valid[grant_id]=0 with fifo_full=0 for TIMEOUT consecutive cycles. Go to IDLE, rr pointer<=grant_id, timeout_pulse=1 for one cycle, pkt_count unchanged.
  - Timeout counter clears on any transfer and holds (does not count) while fifo_full=1.
- Latency:
  - Request to grant: 1 cycle.
  - First transfer: in the first BUSY cycle if the FIFO is not full.
  - Exactly one dead IDLE cycle between consecutive packets.
- en_mask cleared for the granted source mid-packet: ignored; the packet completes or times out.
- Single-beat packet (valid & last on the first BUSY cycle): one transfer, then IDLE.
- Source deasserting valid mid-packet: stall with no write; grant held until last or timeout.
- grant_id keeps its value in IDLE until the next grant.
- Reset mid-packet: immediate return to reset values; the partial packet is not terminated in the FIFO (downstream framing responsibility).

Test Plan:
- Sources 0 and 2 both valid, 3-beat packets, mask=1111, FIFO empty -> grant 0 first (pointer 3 after reset), writes 0's 3 beats, one IDLE cycle, then 2's 3 beats; pkt_count=2.
- All 4 sources continuously valid with 1-beat packets -> grant order 0,1,2,3,0; one write every 2 cycles.
- fifo_full held high 5 cycles mid-packet -> fifo_we=0 and src_ready=0 for those 5 cycles, no timeout, packet resumes intact with no beat lost or duplicated.
- TIMEOUT=4, granted source drops valid after beat 1 -> timeout_pulse on the 4th idle cycle, busy=0 the next cycle, pkt_count unchanged, next eligible source granted.
- mask=0100 with sources 0..3 valid -> only source 2 is ever granted; clearing bit 2 mid-packet still lets its packet finish.
- Assert rst during beat 2 of a packet -> outputs return to reset values asynchronously; after release, arbitration restarts with source 0 first.
